alu_ctrl_stage: RTL
===================

ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 Parameter TRAP_STICKY, default 1; 1 = illegal instruction parks stage in TRAP until TRAP_CLR, 0 = ILLEGAL is a one-cycle pulse and no TRAP state is used.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 INSTR  input  32  RV32I instruction from decode.
REQ-005 PC_IN  input  32  PC of INSTR.
REQ-006 IN_VALID  input  1  INSTR/PC_IN valid this cycle.
REQ-007 STALL  input  1  hold all output registers; input not consumed.
REQ-008 FLUSH  input  1  replace stage contents with a bubble.
REQ-009 TRAP_CLR  input  1  leave TRAP state.
REQ-010 CTRL  output  4  registered ALU op: ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, AND 0101, OR 0110, XOR 0111, SLT 1000, SLTU 1001.
REQ-011 BRANCHCONDITION  output  4  registered: BEQ 1000, BNE 1001, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111, JMP 1010, none 0000.
REQ-012 ASEL  output  2  ALU A source: 00 rs1, 01 PC, 10 zero.
REQ-013 BSEL  output  1  ALU B source: 0 rs2, 1 IMM.
REQ-014 IMM  output  32  sign-extended immediate for the instruction format.
REQ-015 PC_OUT  output  32  registered PC_IN.
REQ-016 RD_OUT  output  5  INSTR[11:7]; forced 0 for branch/store.
REQ-017 OUT_VALID  output  1  stage holds a valid legal instruction.
REQ-018 ILLEGAL  output  1  illegal-instruction indication.
REQ-019 ISSUED  output  32  count of instructions issued (OUT_VALID loads).

Function
REQ-020 Latency SHALL be one cycle: INSTR sampled at edge N appears decoded on outputs after edge N.
REQ-021 Load condition: state RUN, IN_VALID=1, STALL=0, FLUSH=0.
REQ-022 R-type (0110011): BSEL 0, ASEL 00; funct3 000 ADD / SUB if funct7=0100000, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL / SRA if funct7=0100000, 110 OR, 111 AND.
REQ-023 I-ALU (0010011): BSEL 1, I-imm, same funct3 map without SUB; SRAI when funct7=0100000 and funct3=101.
REQ-024 LOAD/STORE: CTRL ADD, ASEL 00, BSEL 1, I-imm / S-imm respectively.
REQ-025 BRANCH (1100011): BSEL 0, ASEL 00, B-imm; BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
REQ-026 JAL: CTRL ADD, ASEL 01, BSEL 1, J-imm, JMP; JALR: CTRL ADD, ASEL 00, BSEL 1, I-imm, JMP.
REQ-027 LUI: CTRL ADD, ASEL 10, BSEL 1, U-imm; AUIPC: CTRL ADD, ASEL 01, BSEL 1, U-imm.
REQ-028 Non-branch, non-jump instructions SHALL drive BRANCHCONDITION 0000.
REQ-029 Illegal: unlisted opcode; R-type funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101; shift-imm funct7 not 0000000/0100000 (0100000 only with 101); branch funct3 010/011; JALR funct3 not 000.
REQ-030 Bubble: OUT_VALID 0, CTRL ADD, BRANCHCONDITION 0000, ASEL 00, BSEL 0, IMM 0, RD_OUT 0; PC_OUT holds.
REQ-031 IN_VALID=0 with STALL=0 and FLUSH=0 SHALL load a bubble.
REQ-032 STALL=1 SHALL hold every output and ISSUED unchanged.
REQ-033 FLUSH SHALL take priority over STALL and over a simultaneous valid INSTR: bubble loaded, ISSUED not incremented.
REQ-034 States RUN and TRAP; RUN->TRAP when load condition holds with an illegal INSTR and TRAP_STICKY=1; bubble loaded, ILLEGAL 1.
REQ-035 In TRAP: inputs ignored, bubble held, ILLEGAL 1; TRAP_CLR=1 -> RUN next edge (FLUSH does not exit TRAP).
REQ-036 TRAP_STICKY=0: illegal load gives bubble and ILLEGAL 1 for exactly one cycle; state stays RUN.
REQ-037 ISSUED SHALL increment by 1 per legal load, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-038 RESET=1 SHALL immediately force state RUN, bubble outputs, PC_OUT 0, ILLEGAL 0, ISSUED 0, independent of CLK, including mid-stall or in TRAP.

Verification
REQ-039 INSTR 0x40208033 (sub x0? rd=0,rs1=1,rs2=2) valid -> next cycle CTRL 0001, BSEL 0, BRANCHCONDITION 0000, OUT_VALID 1, ISSUED 1.
REQ-040 INSTR 0xFE20CEE3 (blt) -> CTRL 1000, BRANCHCONDITION 1100, IMM 0xFFFFFFFC, RD_OUT 0.
REQ-041 Valid JAL with STALL=1 for 3 cycles -> outputs hold previous values; on STALL=0 -> BRANCHCONDITION 1010, ASEL 01.
REQ-042 FLUSH=1 and STALL=1 with valid ADDI -> bubble, ISSUED unchanged.
REQ-043 INSTR 0xFFFFFFFF, TRAP_STICKY=1 -> ILLEGAL 1, OUT_VALID 0 until TRAP_CLR pulse, then next valid ADDI issues.
REQ-044 ISSUED preset near 0xFFFFFFFF via 2^32-1 loads (or forced) -> wraps to 0; RESET mid-TRAP -> ILLEGAL 0, ISSUED 0 asynchronously.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// RV32I decode-to-ALU control stage: one-cycle registered decode of ALU op,
// operand selects, immediate and branch condition, with illegal-instruction trap.
module alu_ctrl_stage #(
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        trap_clr,
  output logic [3:0]  ctrl,
  output logic [3:0]  branchcondition,
  output logic [1:0]  asel,
  output logic        bsel,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic        out_valid,
  output logic        illegal,
  output logic [31:0] issued
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [3:0] BC_NONE = 4'b0000;
  localparam logic [3:0] BC_JMP  = 4'b1010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {RUN, TRAP} state_t;

  state_t state, state_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_ctrl, dec_bc;
  logic [1:0]  dec_asel;
  logic        dec_bsel;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        dec_bad;

  logic        take, issue, next_illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic logic [3:0] alu_map(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_map = ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_ctrl = ALU_ADD;
    dec_bc   = BC_NONE;
    dec_asel = 2'b00;
    dec_bsel = 1'b0;
    dec_imm  = 32'h0;
    dec_rd   = instr[11:7];
    dec_bad  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE)
          dec_ctrl = alu_map(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          dec_ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          dec_ctrl = ALU_SRA;
        else
          dec_bad = 1'b1;
      end
      OP_I: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
        dec_ctrl = alu_map(funct3);
        // Only shift-immediates carry a funct7; SRAI is the sole alternate form
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          dec_bad = 1'b1;
        else if (funct3 == 3'b101 && funct7 == F7_ALT)
          dec_ctrl = ALU_SRA;
        else if (funct3 == 3'b101 && funct7 != F7_BASE)
          dec_bad = 1'b1;
      end
      OP_LOAD: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
      end
      OP_STORE: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_s;
        dec_rd   = 5'd0;
      end
      OP_BRANCH: begin
        dec_imm = imm_b;
        dec_rd  = 5'd0;
        dec_bc  = {1'b1, funct3};
        if (funct3 == 3'b010 || funct3 == 3'b011)
          dec_bad = 1'b1;
        else if (!funct3[2])
          dec_ctrl = ALU_SUB;
        else if (!funct3[1])
          dec_ctrl = ALU_SLT;
        else
          dec_ctrl = ALU_SLTU;
      end
      OP_JAL: begin
        dec_asel = 2'b01;
        dec_bsel = 1'b1;
        dec_imm  = imm_j;
        dec_bc   = BC_JMP;
      end
      OP_JALR: begin
        dec_bsel = 1'b1;
        dec_imm  = imm_i;
        dec_bc   = BC_JMP;
        dec_bad  = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec_asel = 2'b10;
        dec_bsel = 1'b1;
        dec_imm  = imm_u;
      end
      OP_AUIPC: begin
        dec_asel = 2'b01;
        dec_bsel = 1'b1;
        dec_imm  = imm_u;
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // take: the output registers update this edge; issue: a legal instruction lands
  assign take  = (state == TRAP) || flush || !stall;
  assign issue = (state == RUN) && !flush && !stall && in_valid && !dec_bad;
  assign next_illegal = (state == TRAP) ? !trap_clr : (!flush && in_valid && dec_bad);

  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (TRAP_STICKY && !flush && !stall && in_valid && dec_bad) state_next = TRAP;
      TRAP: if (trap_clr) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Anything other than a legal issue loads a bubble; PC_OUT only moves on issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl            <= ALU_ADD;
      branchcondition <= BC_NONE;
      asel            <= 2'b00;
      bsel            <= 1'b0;
      imm             <= 32'h0;
      rd_out          <= 5'd0;
      out_valid       <= 1'b0;
      pc_out          <= 32'h0;
      illegal         <= 1'b0;
      issued          <= 32'h0;
    end else if (take) begin
      ctrl            <= issue ? dec_ctrl : ALU_ADD;
      branchcondition <= issue ? dec_bc   : BC_NONE;
      asel            <= issue ? dec_asel : 2'b00;
      bsel            <= issue ? dec_bsel : 1'b0;
      imm             <= issue ? dec_imm  : 32'h0;
      rd_out          <= issue ? dec_rd   : 5'd0;
      out_valid       <= issue;
      illegal         <= next_illegal;
      if (issue) begin
        pc_out <= pc_in;
        issued <= issued + 32'd1;
      end
    end
  end

endmodule
